// File: rtl/reset_sequencer.sv
// reset_sequencer: lock-filtered, settle-delayed, ordered release of N active-low reset domains.
// Define STEP_MODE_EN to add the single-step clock enable (step_mode/step ports).
module reset_sequencer #(
    parameter int N_DOMAINS     = 3,
    parameter int LOCK_FILTER   = 4,
    parameter int SETTLE_CYCLES = 65535,
    parameter int GAP_CYCLES    = 16
) (
    input  logic                 CLK,
    input  logic                 RESET,
    input  logic                 pll_locked,
    input  logic                 soft_reset_req,
`ifdef STEP_MODE_EN
    input  logic                 step_mode,
    input  logic                 step,
`endif
    output logic [N_DOMAINS-1:0] resetn,
    output logic                 ready,
    output logic                 ce
);
    localparam int LW = $clog2(LOCK_FILTER + 1);
    localparam int SW = $clog2(SETTLE_CYCLES + 1);
    localparam int GW = $clog2(GAP_CYCLES + 1);
    localparam int IW = $clog2(N_DOMAINS + 1);

    typedef enum logic [1:0] {WAIT_LOCK, SETTLE, RELEASE, RUN} state_t;

    state_t                 state_q, state_d;
    logic                   lock_s1_q, lock_s1_d, lock_q, lock_d;
    logic [LW-1:0]          lock_cnt_q, lock_cnt_d;
    logic [SW-1:0]          settle_cnt_q, settle_cnt_d;
    logic [GW-1:0]          gap_cnt_q, gap_cnt_d;
    logic [IW-1:0]          idx_q, idx_d;
    logic [N_DOMAINS-1:0]   resetn_q, resetn_d;
    logic                   ready_q, ready_d;

    always_comb begin
        lock_s1_d    = pll_locked;
        lock_d       = lock_s1_q;
        state_d      = state_q;
        lock_cnt_d   = '0;
        settle_cnt_d = settle_cnt_q;
        gap_cnt_d    = gap_cnt_q;
        idx_d        = idx_q;
        resetn_d     = resetn_q;
        ready_d      = ready_q;
        // lock loss outranks a soft reset request in the same cycle
        if (state_q != WAIT_LOCK && !lock_q) begin
            state_d      = WAIT_LOCK;
            settle_cnt_d = '0;
            gap_cnt_d    = '0;
            idx_d        = '0;
            resetn_d     = '0;
            ready_d      = 1'b0;
        end else if ((state_q == RELEASE || state_q == RUN) && soft_reset_req) begin
            state_d      = SETTLE;
            settle_cnt_d = '0;
            gap_cnt_d    = '0;
            idx_d        = '0;
            resetn_d     = '0;
            ready_d      = 1'b0;
        end else begin
            case (state_q)
                WAIT_LOCK: begin
                    if (lock_q && lock_cnt_q == LW'(LOCK_FILTER - 1)) begin
                        state_d      = SETTLE;
                        settle_cnt_d = '0;
                    end else if (lock_q) begin
                        lock_cnt_d = lock_cnt_q + 1'b1;
                    end
                end
                SETTLE: begin
                    if (settle_cnt_q == SW'(SETTLE_CYCLES - 1)) begin
                        state_d     = (N_DOMAINS == 1) ? RUN : RELEASE;
                        resetn_d[0] = 1'b1;
                        ready_d     = (N_DOMAINS == 1);
                        idx_d       = '0;
                        gap_cnt_d   = '0;
                    end else begin
                        settle_cnt_d = settle_cnt_q + 1'b1;
                    end
                end
                RELEASE: begin
                    // released bits are contiguous from 0, so shifting in a 1 frees domain idx+1
                    if (gap_cnt_q == GW'(GAP_CYCLES - 1)) begin
                        resetn_d  = (resetn_q << 1) | N_DOMAINS'(1);
                        idx_d     = idx_q + 1'b1;
                        gap_cnt_d = '0;
                        state_d   = (int'(idx_q) == N_DOMAINS - 2) ? RUN : RELEASE;
                        ready_d   = (int'(idx_q) == N_DOMAINS - 2);
                    end else begin
                        gap_cnt_d = gap_cnt_q + 1'b1;
                    end
                end
                RUN: state_d = RUN;
                default: state_d = WAIT_LOCK;
            endcase
        end
    end

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            state_q      <= WAIT_LOCK;
            lock_s1_q    <= 1'b0;
            lock_q       <= 1'b0;
            lock_cnt_q   <= '0;
            settle_cnt_q <= '0;
            gap_cnt_q    <= '0;
            idx_q        <= '0;
            resetn_q     <= '0;
            ready_q      <= 1'b0;
        end else begin
            state_q      <= state_d;
            lock_s1_q    <= lock_s1_d;
            lock_q       <= lock_d;
            lock_cnt_q   <= lock_cnt_d;
            settle_cnt_q <= settle_cnt_d;
            gap_cnt_q    <= gap_cnt_d;
            idx_q        <= idx_d;
            resetn_q     <= resetn_d;
            ready_q      <= ready_d;
        end
    end

    assign resetn = resetn_q;
    assign ready  = ready_q;

`ifdef STEP_MODE_EN
    logic step_s1_q, step_s1_d, step_s2_q, step_s2_d, step_s3_q, step_s3_d, ce_q, ce_d;

    always_comb begin
        step_s1_d = step;
        step_s2_d = step_s1_q;
        step_s3_d = step_s2_q;
        ce_d      = step_mode ? (step_s2_q & ~step_s3_q) : 1'b1;
    end

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            step_s1_q <= 1'b0;
            step_s2_q <= 1'b0;
            step_s3_q <= 1'b0;
            ce_q      <= 1'b1;
        end else begin
            step_s1_q <= step_s1_d;
            step_s2_q <= step_s2_d;
            step_s3_q <= step_s3_d;
            ce_q      <= ce_d;
        end
    end

    assign ce = ce_q;
`else
    assign ce = 1'b1;
`endif
endmodule

// File: tb/tb_reset_sequencer.sv
// tb_reset_sequencer: randomized scoreboard bench; expected resetn/ready derived from event times.
module tb_reset_sequencer;
    localparam int N  = 3;
    localparam int LF = 4;
    localparam int SC = 32;
    localparam int GC = 8;

    logic         CLK = 1'b0;
    logic         RESET = 1'b1;
    logic         pll_locked = 1'b0;
    logic         soft_reset_req = 1'b0;
`ifdef STEP_MODE_EN
    logic         step_mode = 1'b0;
    logic         step = 1'b0;
`endif
    logic [N-1:0] resetn;
    logic         ready;
    logic         ce;

    int           tests = 0;
    int           fails = 0;
    bit           step_on = 1'b0;
    logic [N:0]   exp_q[$];

    reset_sequencer #(.N_DOMAINS(N), .LOCK_FILTER(LF), .SETTLE_CYCLES(SC), .GAP_CYCLES(GC)) dut (
        .CLK(CLK),
        .RESET(RESET),
        .pll_locked(pll_locked),
        .soft_reset_req(soft_reset_req),
`ifdef STEP_MODE_EN
        .step_mode(step_mode),
        .step(step),
`endif
        .resetn(resetn),
        .ready(ready),
        .ce(ce)
    );

    always #5 CLK = ~CLK;

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
        tests++;
        if (got !== want) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, got, want, $time);
        end
    endtask

    // domains released at edge t for a sequence whose settle phase began at edge s
    function automatic int released(input int s, input int t);
        int r;
        if (s < 0 || t - s < SC) return 0;
        r = 1 + (t - s - SC) / GC;
        return (r < N) ? r : N;
    endfunction

    initial begin : model
        int e, start, run, r, prev;
        logic h1, h2, lk;
        e = 0; start = -1; run = 0; h1 = 1'b0; h2 = 1'b0;
        forever begin
            @(posedge CLK or posedge RESET);
            if (RESET) begin
                e = 0; start = -1; run = 0; h1 = 1'b0; h2 = 1'b0;
            end else begin
                lk = h2;
                h2 = h1;
                h1 = pll_locked;
                prev = released(start, e);
                e++;
                if (start < 0) begin
                    run = lk ? run + 1 : 0;
                    if (run == LF) begin
                        start = e;
                        run = 0;
                    end
                end else if (!lk) begin
                    start = -1;
                    run = 0;
                end else if (soft_reset_req && prev > 0) begin
                    start = e;
                end
                r = released(start, e);
                exp_q.push_back({r == N, N'((1 << r) - 1)});
            end
        end
    end

    initial begin : monitor
        logic [N:0] x;
        forever begin
            @(posedge CLK);
            #1;
            if (exp_q.size() > 0) begin
                x = exp_q.pop_front();
                chk("resetn", {29'b0, resetn}, {29'b0, x[N-1:0]});
                chk("ready", {31'b0, ready}, {31'b0, x[N]});
            end
            if (!step_on) chk("ce_free", {31'b0, ce}, 32'd1);
        end
    end

    task automatic cycles(input int n);
        repeat (n) @(negedge CLK);
    endtask

    task automatic wait_rn(input logic [N-1:0] v, input string name);
        for (int i = 0; i < 300 && resetn !== v; i++) @(negedge CLK);
        chk(name, {29'b0, resetn}, {29'b0, v});
    endtask

`ifdef STEP_MODE_EN
    task automatic press();
        @(negedge CLK);
        step = 1'b1;
        for (int k = 1; k <= 6; k++) begin
            @(posedge CLK);
            #1;
            chk("ce_step", {31'b0, ce}, {31'b0, k == 3});
        end
        @(negedge CLK);
        step = 1'b0;
        cycles(4);
    endtask
`endif

    initial begin : driver
        #1;
        chk("rst_resetn", {29'b0, resetn}, 32'd0);
        chk("rst_ready", {31'b0, ready}, 32'd0);
        chk("rst_ce", {31'b0, ce}, 32'd1);
        cycles(5);
        RESET = 1'b0;
        cycles(5);
        pll_locked = 1'b1;
        cycles(80);
        pll_locked = 1'b0;
        cycles(1);
        pll_locked = 1'b1;
        cycles(3);
        pll_locked = 1'b0;
        cycles(1);
        pll_locked = 1'b1;
        cycles(90);
        soft_reset_req = 1'b1;
        cycles(1);
        soft_reset_req = 1'b0;
        wait_rn(3'b011, "reach_011");
        soft_reset_req = 1'b1;
        cycles(1);
        soft_reset_req = 1'b0;
        cycles(70);
        pll_locked = 1'b0;
        cycles(2);
        soft_reset_req = 1'b1;
        cycles(1);
        soft_reset_req = 1'b0;
        cycles(2);
        pll_locked = 1'b1;
        cycles(80);
        for (int i = 0; i < 800; i++) begin
            pll_locked = ($urandom_range(0, 149) != 0);
            soft_reset_req = ($urandom_range(0, 29) == 0);
            cycles(1);
        end
        pll_locked = 1'b1;
        soft_reset_req = 1'b0;
        wait_rn(3'b001, "reach_001");
        cycles(3);
        #2;
        RESET = 1'b1;
        #1;
        chk("async_resetn", {29'b0, resetn}, 32'd0);
        chk("async_ready", {31'b0, ready}, 32'd0);
        chk("async_ce", {31'b0, ce}, 32'd1);
        cycles(2);
        RESET = 1'b0;
        cycles(70);
`ifdef STEP_MODE_EN
        step_on = 1'b1;
        step_mode = 1'b1;
        cycles(3);
        press();
        press();
        step_mode = 1'b0;
        cycles(2);
        step_on = 1'b0;
        cycles(3);
`endif
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
